// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with glitch-free run-time ratio updates.
// New ratios are applied only at period boundaries via a DRAIN/LOAD step.
module clk_div_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_LOAD  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nx;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_nx;
  logic [DIV_W-1:0] pend_div;
  logic             up;
  logic             xfer;
  logic             legal;
  logic             last;
  logic             counting_nx;

  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = cfg_div >= TWO;
  assign last      = cnt == div_reg - ONE;
  assign cnt_inc   = last ? '0 : cnt + ONE;
  assign cfg_ready = up && (state == S_IDLE || state == S_RUN);
  assign busy      = state != S_IDLE;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    div_nx   = div_reg;
    unique case (1'b1)
      (state == S_IDLE): begin
        cnt_nx = '0;
        if (xfer) begin
          if (legal) state_nx = S_LOAD;
        end else if (en) begin
          state_nx = S_RUN;
        end
      end
      (state == S_RUN): begin
        cnt_nx = cnt_inc;
        if (xfer && legal) state_nx = S_DRAIN;
        else if (!en && last) state_nx = S_IDLE;
      end
      (state == S_DRAIN): begin
        cnt_nx = cnt_inc;
        if (last) state_nx = S_LOAD;
      end
      default: begin
        cnt_nx   = '0;
        div_nx   = pend_div;
        state_nx = en ? S_RUN : S_IDLE;
      end
    endcase
  end

  // outputs are registered from next-state values so they align with cnt
  assign counting_nx = state_nx == S_RUN || state_nx == S_DRAIN;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_reg  <= DIV_RST;
      pend_div <= DIV_RST;
      up       <= 1'b0;
      cfg_err  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      div_reg <= div_nx;
      up      <= 1'b1;
      cfg_err <= xfer && !legal;
      if (xfer && legal) pend_div <= cfg_div;
      clk_out <= counting_nx && (cnt_nx < (div_nx >> 1));
      tick    <= counting_nx && (cnt_nx == div_nx - ONE);
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: per-cycle expected outputs are
// derived from the divide ratio and compared one cycle later.
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       tick;
  logic       busy;

  clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(10)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cfg_valid(cfg_valid),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err(cfg_err),
    .clk_out(clk_out),
    .tick(tick),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [4:0] v;
  } exp_t;

  exp_t q[$];
  int   n_run;
  int   n_fail;
  int   mc;
  int   md;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (clk_out,tick,busy,ready,err)",
               tag, got, exp);
    end
  endtask

  // push expectation, let the DUT take one edge, pop and compare
  task automatic step_exp(string tag, logic [4:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check(e.tag, {27'd0, clk_out, tick, busy, cfg_ready, cfg_err},
          {27'd0, e.v});
  endtask

  task automatic run(string tag, int n, logic rdy, logic err);
    for (int i = 0; i < n; i++) begin
      step_exp(tag, {(mc < md / 2) ? 1'b1 : 1'b0,
                     (mc == md - 1) ? 1'b1 : 1'b0,
                     1'b1, rdy, err});
      mc = (mc == md - 1) ? 0 : mc + 1;
    end
  endtask

  task automatic reconfig(string tag, int n);
    cfg_valid = 1'b1;
    cfg_div   = 8'(n);
    run(tag, 1, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    for (int k = 0; k < 300 && mc != 0; k++) run(tag, 1, 1'b0, 1'b0);
    step_exp({tag, "_load"}, 5'b00100);
    md = n;
    mc = 0;
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    rst       = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = 8'd0;
    step_exp("reset", 5'b00000);
    step_exp("reset", 5'b00000);

    rst = 1'b1;
    en  = 1'b1;
    md  = 10;
    mc  = 0;
    run("div10", 30, 1'b1, 1'b0);

    run("en_drop", 3, 1'b1, 1'b0);
    en = 1'b0;
    run("en_drop", 7, 1'b1, 1'b0);
    step_exp("idle", 5'b00010);
    step_exp("idle", 5'b00010);

    cfg_valid = 1'b1;
    cfg_div   = 8'd5;
    step_exp("load5", 5'b00100);
    cfg_valid = 1'b0;
    en        = 1'b1;
    md        = 5;
    mc        = 0;
    run("div5", 15, 1'b1, 1'b0);

    cfg_valid = 1'b1;
    cfg_div   = 8'd1;
    run("err1", 1, 1'b1, 1'b1);
    cfg_valid = 1'b0;
    run("err1", 2, 1'b1, 1'b0);
    cfg_valid = 1'b1;
    cfg_div   = 8'd0;
    run("err0", 1, 1'b1, 1'b1);
    cfg_valid = 1'b0;
    run("err0", 6, 1'b1, 1'b0);

    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    run("drain", 1, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    run("drain", 1, 1'b0, 1'b0);
    rst = 1'b0;
    step_exp("rst_mid", 5'b00000);
    step_exp("rst_mid", 5'b00000);
    rst = 1'b1;
    md  = 10;
    mc  = 0;
    run("after_rst", 34, 1'b1, 1'b0);

    reconfig("cfg4", 4);
    run("div4", 12, 1'b1, 1'b0);

    reconfig("cfg255", 255);
    run("div255", 520, 1'b1, 1'b0);

    reconfig("cfg2", 2);
    run("div2", 8, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
